// File: rtl/rx_escape.sv
// Receive-side escape decoder: strips ESC prefixes, flags commands and
// buffers decoded {command, data} symbols in a small first-word-fall-through FIFO.
module rx_escape #(
    parameter logic [7:0]  ESC   = 8'hB1,
    parameter int unsigned DEPTH = 4
) (
    input  logic       CLK_I,
    input  logic       RST_NI,
    input  logic [7:0] DATA_RECV_I,
    input  logic       RX_VALID_I,
    output logic [7:0] DATA_RECV_O,
    output logic       COMMAND_O,
    output logic       VALID_O,
    input  logic       READ_I,
    output logic       OVERRUN_O,
    input  logic       CLEAR_I
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned SW = 9;

    typedef enum logic {
        S_NORMAL = 1'b0,
        S_ESC    = 1'b1
    } state_t;

    state_t          state;
    logic [SW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;

    logic            sym_valid;
    logic [SW-1:0]   sym_word;
    logic            full;
    logic            pop;
    logic            push;
    logic            is_esc;

    // Symbol produced by the current strobe, if any
    always_comb begin
        sym_valid = 1'b0;
        sym_word  = '0;
        is_esc    = (DATA_RECV_I == ESC);
        if (RX_VALID_I) begin
            case (state)
                S_NORMAL: begin
                    sym_valid = !is_esc;
                    sym_word  = {1'b0, DATA_RECV_I};
                end
                S_ESC: begin
                    sym_valid = 1'b1;
                    sym_word  = {!is_esc, DATA_RECV_I};
                end
                default: begin
                    sym_valid = 1'b0;
                    sym_word  = '0;
                end
            endcase
        end
    end

    assign full = (count == (AW + 1)'(DEPTH));
    assign pop  = READ_I && VALID_O && !CLEAR_I;
    // A full FIFO still accepts a symbol when the head is popped on the same edge
    assign push = sym_valid && (!full || pop) && !CLEAR_I;

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state     <= S_NORMAL;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            OVERRUN_O <= 1'b0;
        end else if (CLEAR_I) begin
            state     <= S_NORMAL;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            OVERRUN_O <= 1'b0;
        end else begin
            if (RX_VALID_I) begin
                state <= (state == S_NORMAL && is_esc) ? S_ESC : S_NORMAL;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW + 1)'(1);
            end
            if (sym_valid && !push) begin
                OVERRUN_O <= 1'b1;
            end
        end
    end

    // Storage carries no reset; entries are only observed while counted valid
    always_ff @(posedge CLK_I) begin
        if (push) begin
            mem[wr_ptr] <= sym_word;
        end
    end

    assign VALID_O     = (count != '0);
    assign DATA_RECV_O = VALID_O ? mem[rd_ptr][7:0] : 8'h00;
    assign COMMAND_O   = VALID_O ? mem[rd_ptr][8]   : 1'b0;

endmodule
